// File: rtl/weight_stream_pkg.sv
// Shared types and sizing helpers for the weight streaming sequencer.
package weight_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Bits needed to hold a credit count of 0..fifo_depth.
    function automatic int credit_width(input int fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction

endpackage

// File: rtl/weight_stream_fifo.sv
// Small synchronous FIFO with async reset; push and pop may coincide at any
// occupancy, including full, since the pop frees the slot being written.
module weight_stream_fifo
    import weight_stream_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 wdata,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 rdata,
    output logic                             full,
    output logic                             empty,
    output logic [credit_width(DEPTH)-1:0]   count
);
    localparam int CW = credit_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/weight_stream_ctrl.sv
// Streams a ROM-resident weight tensor repeat_count times with credit-based
// issue into an output FIFO. Define WEIGHT_STREAM_LAST_EN to add data_out_last.
module weight_stream_ctrl
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 576,
    parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
    parameter int ROM_LATENCY  = 2,
    parameter int FIFO_DEPTH   = ROM_LATENCY + 2,
    parameter int REPEAT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [REPEAT_WIDTH-1:0] repeat_count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rom_address0,
    output logic                    rom_ce0,
    input  logic [DATA_WIDTH-1:0]   rom_q0,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_out_valid,
    input  logic                    data_out_ready
`ifdef WEIGHT_STREAM_LAST_EN
    ,
    output logic                    data_out_last
`endif
);
    localparam int CW = credit_width(FIFO_DEPTH);
    localparam int SW = CW + 1;
`ifdef WEIGHT_STREAM_LAST_EN
    localparam int FW = DATA_WIDTH + 1;
`else
    localparam int FW = DATA_WIDTH;
`endif

    state_t                  state;
    state_t                  state_nx;
    logic [REPEAT_WIDTH-1:0] rep_q;
    logic [REPEAT_WIDTH-1:0] pass_cnt;
    logic [ROM_LATENCY-1:0]  tokens;
    logic [SW-1:0]           credits_used;
    logic                    issue;
    logic                    addr_at_end;
    logic                    final_issue;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [CW-1:0]           count;
    logic [FW-1:0]           wdata;
    logic [FW-1:0]           rdata;

    assign addr_at_end = (rom_address0 == ADDR_WIDTH'(DEPTH - 1));
    assign final_issue = addr_at_end && (pass_cnt == rep_q - 1'b1);

    // Pre-pop credit: a beat leaving this cycle does not free a slot until next cycle.
    always_comb begin
        credits_used = SW'(count);
        for (int i = 0; i < ROM_LATENCY; i++)
            credits_used = credits_used + SW'(tokens[i]);
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        rom_ce0  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (repeat_count != '0) ? RUN : FIN;
            end
            RUN: begin
                busy    = 1'b1;
                rom_ce0 = 1'b1;
                issue   = !full && (credits_used < SW'(FIFO_DEPTH));
                if (issue && final_issue)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                rom_ce0 = 1'b1;
                if (tokens == '0 && empty)
                    state_nx = FIN;
            end
            FIN: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rom_address0 <= '0;
            pass_cnt     <= '0;
            rep_q        <= '0;
            tokens       <= '0;
        end else begin
            state  <= state_nx;
            tokens <= (tokens << 1) | ROM_LATENCY'(issue);
            if (state == IDLE && start) begin
                rep_q        <= repeat_count;
                pass_cnt     <= '0;
                rom_address0 <= '0;
            end else if (issue) begin
                if (addr_at_end) begin
                    rom_address0 <= '0;
                    pass_cnt     <= pass_cnt + 1'b1;
                end else begin
                    rom_address0 <= rom_address0 + 1'b1;
                end
            end
        end
    end

    // A token leaving the pipe marks rom_q0 as the data for that issued address.
    assign push           = tokens[ROM_LATENCY-1];
    assign data_out_valid = !empty;
    assign pop            = data_out_valid && data_out_ready;

`ifdef WEIGHT_STREAM_LAST_EN
    logic [ROM_LATENCY-1:0] last_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_pipe <= '0;
        else
            last_pipe <= (last_pipe << 1) | ROM_LATENCY'(issue && addr_at_end);
    end

    assign wdata         = {last_pipe[ROM_LATENCY-1], rom_q0};
    assign data_out      = rdata[DATA_WIDTH-1:0];
    assign data_out_last = rdata[DATA_WIDTH];
`else
    assign wdata    = rom_q0;
    assign data_out = rdata;
`endif

    weight_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl with a 4-word ROM holding word i = i.
module tb_weight_stream_ctrl;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int AW = 3;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   repeat_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_address0;
    logic          rom_ce0;
    logic [DW-1:0] rom_q0 = '0;
    logic [DW-1:0] rom_s1 = '0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
`ifdef WEIGHT_STREAM_LAST_EN
    logic          data_out_last;
`endif

    always #5 clk = ~clk;

    weight_stream_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .repeat_count   (repeat_count),
        .busy           (busy),
        .done           (done),
        .rom_address0   (rom_address0),
        .rom_ce0        (rom_ce0),
        .rom_q0         (rom_q0),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef WEIGHT_STREAM_LAST_EN
        ,
        .data_out_last  (data_out_last)
`endif
    );

    // Two-stage registered ROM, word i = i.
    always @(posedge clk) begin
        if (rom_ce0) begin
            rom_s1 <= DW'(rom_address0);
            rom_q0 <= rom_s1;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // 0 = ready low, 1 = ready high, 2 = random ready
    int ready_mode = 1;
    initial begin
        data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_out_ready = 1'b0;
                2:       data_out_ready = 1'($urandom_range(0, 1));
                default: data_out_ready = 1'b1;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] beat_data[$];
    logic          beat_last[$];
    int            beat_cyc[$];
    int            done_cnt, done_cyc, done_busy, first_valid, busy_fall;
    int            issues, max_out, t0;
    bit            ce_seen, busy_prev, stall_prev;
    logic [DW-1:0] data_prev;
    logic [AW-1:0] addr_prev;

    task automatic clear_mon();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        done_busy   = 0;
        first_valid = -1;
        busy_fall   = -1;
        issues      = 0;
        max_out     = 0;
        ce_seen     = 0;
        busy_prev   = busy;
        stall_prev  = 0;
        addr_prev   = rom_address0;
    endtask

    always @(negedge clk) begin
        if (stall_prev && data_out_valid)
            check("hold_while_stalled", 32'(data_out), 32'(data_prev));
        stall_prev = data_out_valid && !data_out_ready;
        data_prev  = data_out;
        if (data_out_valid && first_valid < 0)
            first_valid = cyc;
        if (data_out_valid && data_out_ready) begin
            beat_data.push_back(data_out);
            beat_cyc.push_back(cyc);
`ifdef WEIGHT_STREAM_LAST_EN
            beat_last.push_back(data_out_last);
`else
            beat_last.push_back(1'b0);
`endif
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = int'(busy);
        end
        if (rom_ce0)
            ce_seen = 1;
        if (busy_prev && !busy && busy_fall < 0)
            busy_fall = cyc;
        busy_prev = busy;
        if (rom_address0 != addr_prev)
            issues++;
        addr_prev = rom_address0;
        if (issues - beat_data.size() > max_out)
            max_out = issues - beat_data.size();
    end

    always @(negedge clk) begin
        assert (!(dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop))
        else $error("FAIL fifo_overflow at t=%0t", $time);
    end

    task automatic start_pulse(input logic [15:0] rc);
        @(posedge clk);
        #1;
        clear_mon();
        start        = 1'b1;
        repeat_count = rc;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input int n_exp);
        check({tag, "_beats"}, 32'(beat_data.size()), 32'(n_exp));
        for (int i = 0; i < beat_data.size() && i < n_exp; i++) begin
            check({tag, "_data"}, 32'(beat_data[i]), 32'(i % DEPTH));
`ifdef WEIGHT_STREAM_LAST_EN
            check({tag, "_last"}, 32'(beat_last[i]), 32'((i % DEPTH) == DEPTH - 1));
`endif
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        repeat_count = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_ce0", 32'(rom_ce0), 32'd0);
        check("rst_addr", 32'(rom_address0), 32'd0);

        // single pass, ready high
        ready_mode = 1;
        start_pulse(16'd1);
        wait_done("t1_done_seen", 100);
        check("t1_latency", 32'(first_valid - t0), 32'd4);
        check_stream("t1", 4);
        if (beat_cyc.size() == 4)
            check("t1_back_to_back", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
        check("t1_done_after_last", 32'(beat_cyc.size() == 4 && done_cyc > beat_cyc[3]), 32'd1);
        check("t1_busy_fall", 32'(busy_fall - done_cyc), 32'd1);

        // three passes, ready high
        start_pulse(16'd3);
        wait_done("t2_done_seen", 200);
        check_stream("t2", 12);
        if (beat_cyc.size() == 12)
            check("t2_throughput", 32'(beat_cyc[11] - beat_cyc[0]), 32'd11);

        // random backpressure, two passes
        ready_mode = 2;
        start_pulse(16'd2);
        wait_done("t3_done_seen", 500);
        check_stream("t3", 8);
        check("t3_credit_bound", 32'(max_out <= FD), 32'd1);
        ready_mode = 1;

        // zero repeat count
        start_pulse(16'd0);
        wait_done("t4_done_seen", 20);
        check("t4_done_latency", 32'(done_cyc - t0), 32'd1);
        check("t4_done_busy", 32'(done_busy), 32'd1);
        check("t4_beats", 32'(beat_data.size()), 32'd0);
        check("t4_ce_seen", 32'(ce_seen), 32'd0);

        // second start during RUN is ignored
        start_pulse(16'd2);
        start        = 1'b1;
        repeat_count = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5_done_seen", 200);
        check_stream("t5", 8);

        // reset in DRAIN with beats pending, then restart
        ready_mode = 0;
        start_pulse(16'd1);
        repeat (10) @(negedge clk);
        check("t6_valid_pre", 32'(data_out_valid), 32'd1);
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_outstanding", 32'(max_out), 32'(FD));
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(data_out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ce0", 32'(rom_ce0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        ready_mode = 1;
        start_pulse(16'd1);
        wait_done("t6_done_seen", 100);
        check_stream("t6", 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
